tusca_uc_multi: RTL and testbench
=================================

Name: tusca_uc_multi

Overview:
Parametrised successor of the TUSCA control unit.
- Sweeps N_SENSORES sensors round-robin, one measurement at a time.
- Waits a programmable inter-sweep delay, then starts the next sweep.
- Accepts configuration requests only during the delay.
- Delay and measurement-timeout counters are internal. A per-sensor sticky timeout flag lets a dead sensor be skipped instead of hanging the unit.
- Sits between the top-level datapath (sensor drivers, config receiver) and the debug display.

Parameters:
N_SENSORES, 4, number of sensor channels (1..16)
DELAY_CICLOS, 50000000, clock cycles spent in ESPERA_DELAY between sweeps (>=2)
TIMEOUT_CICLOS, 5000000, maximum cycles to wait for pronto_medida per sensor (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  leaves INICIAL, begins first sweep
parar  in  1  stop request, honoured only in ESPERA_DELAY
pronto_medida  in  1  selected sensor finished measuring
definir_config  in  1  user requests a configuration update
pronto_config  in  1  configuration receiver finished
medir  out  N_SENSORES  one-hot, one-cycle measurement pulse to selected sensor
sensor_sel  out  CW  index of current sensor, CW = max(1,$clog2(N_SENSORES))
receber_config  out  1  one-cycle pulse to configuration receiver
fim_ciclo  out  1  one-cycle pulse when a sweep completes
erro_timeout  out  N_SENSORES  sticky per-sensor timeout flags
db_estado  out  4  current state code

Behaviour:
- Reset (synchronous, active-high, any state) gives:
  - state INICIAL, sensor_sel=0, both counters 0, erro_timeout=0.
  - medir, receber_config and fim_ciclo all 0.
- All outputs are Moore (decoded from registered state/regs). db_estado equals the state code.
- States and codes:
  - INICIAL (0): start -> MEDE, with sensor_sel=0. start is ignored in every other state.
  - MEDE (1): medir[sensor_sel]=1 for this single cycle; timeout counter cleared. -> ESPERA_MEDIDA.
  - ESPERA_MEDIDA (2): timeout counter increments each cycle.
    - pronto_medida -> PROXIMO; clears erro_timeout[sensor_sel].
    - else if counter == TIMEOUT_CICLOS-1 -> PROXIMO; sets erro_timeout[sensor_sel].
    - pronto_medida on the same cycle as the timeout: pronto wins, no error.
  - PROXIMO (3):
    - If sensor_sel == N_SENSORES-1: sensor_sel <= 0, fim_ciclo=1 this cycle, -> RESETA_DELAY.
    - Else: sensor_sel <= sensor_sel+1, -> MEDE.
  - RESETA_DELAY (4): delay counter cleared. -> ESPERA_DELAY.
  - ESPERA_DELAY (5): delay counter increments. Exit priority, highest first:
    1. counter == DELAY_CICLOS-1 -> MEDE.
    2. parar -> INICIAL.
    3. definir_config -> PEDIR_CONFIG.
    4. otherwise stay.
  - PEDIR_CONFIG (6): receber_config=1 for one cycle. -> ESPERA_CONFIG.
  - ESPERA_CONFIG (7): pronto_config -> RESETA_DELAY, so the full delay restarts. No timeout on config.
  - Unused codes (8..15): -> INICIAL next cycle, outputs inactive.
- Timing:
  - An uninterrupted ESPERA_DELAY lasts exactly DELAY_CICLOS cycles.
  - A timed-out sensor occupies ESPERA_MEDIDA for exactly TIMEOUT_CICLOS cycles.
  - If pronto_medida is high on the first ESPERA_MEDIDA cycle, that sensor's MEDE->PROXIMO path takes 2 cycles.
- Input sampling:
  - definir_config and parar are ignored outside ESPERA_DELAY; they are level-sampled, not latched.
  - pronto_medida outside ESPERA_MEDIDA is ignored.
- Counters:
  - Width is $clog2(max(DELAY_CICLOS,TIMEOUT_CICLOS)), or separate per-counter widths.
  - Counters never wrap, because the state exits at terminal count.
- N_SENSORES=1: sensor_sel is held at 0 (1 bit), and fim_ciclo pulses after every measurement.

Decomposition:
- Package tusca_uc_pkg holds:
  - the 4-bit state encodings listed above;
  - localparam helpers for CW and counter widths.
- Natural sub-module: tusca_contador_m, a modulo-M counter.
  - Parameter M; inputs zera and conta; outputs q and fim (q == M-1).
  - Instantiated twice: delay with M=DELAY_CICLOS, timeout with M=TIMEOUT_CICLOS.
- Bench uses small parameters: DELAY_CICLOS=10, TIMEOUT_CICLOS=6, N_SENSORES=3.

Test Plan:
- Reset then start; all sensors answer pronto_medida 3 cycles after their medir:
  - medir pulses 001, 010, 100 in order, with sensor_sel 0, 1, 2;
  - fim_ciclo pulses once;
  - exactly 10 cycles in state 5, then medir=001 again.
- Sensor 1 never answers: ESPERA_MEDIDA for sensor 1 lasts 6 cycles, erro_timeout=010, then medir=100. Next sweep sensor 1 answers, so erro_timeout returns to 000.
- pronto_medida asserted on the same cycle the timeout counter reaches 5: erro_timeout stays 000.
- definir_config on delay cycle 4:
  - receber_config pulses for one cycle;
  - pronto_config 5 cycles later -> RESETA_DELAY;
  - the full 10-cycle delay then restarts before medir.
- fim_delay, parar and definir_config all high on delay cycle 9: goes to MEDE. parar at delay cycle 3 instead: goes to INICIAL and a later start restarts from sensor 0.
- Synchronous reset asserted mid-ESPERA_MEDIDA and mid-ESPERA_CONFIG: next edge gives db_estado=0, erro_timeout=0, sensor_sel=0, all pulses low. start while not in INICIAL has no effect.

Source files
------------

// File: rtl/tusca_uc_pkg.sv
// Shared definitions for the TUSCA multi-sensor control unit:
// state encodings and width helpers for the selector and counters.
package tusca_uc_pkg;

   typedef enum logic [3:0] {
      INICIAL       = 4'd0,
      MEDE          = 4'd1,
      ESPERA_MEDIDA = 4'd2,
      PROXIMO       = 4'd3,
      RESETA_DELAY  = 4'd4,
      ESPERA_DELAY  = 4'd5,
      PEDIR_CONFIG  = 4'd6,
      ESPERA_CONFIG = 4'd7
   } estado_t;

   localparam int ESTADO_W = 4;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int largura(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tusca_contador_m.sv
// Modulo-M up counter with synchronous clear. fim flags the terminal
// value M-1; the controller leaves the counting state on that value.
module tusca_contador_m
   import tusca_uc_pkg::*;
#(
   parameter  int M = 10,
   localparam int W = largura(M)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   output logic [W-1:0] q,
   output logic         fim
);

   logic [W-1:0] q_q, q_d;

   assign fim = (q_q == W'(M - 1));
   assign q   = q_q;

   // Next count: clear has priority, otherwise step modulo M.
   always_comb begin
      q_d = q_q;
      if (zera) begin
         q_d = '0;
      end else if (conta) begin
         q_d = fim ? '0 : q_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clock) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: rtl/tusca_uc_multi.sv
// TUSCA control unit, multi-sensor version. Sweeps the sensors round-robin,
// marks sensors that miss their measurement deadline with a sticky flag,
// waits a programmable delay between sweeps and accepts configuration
// requests only while waiting.
module tusca_uc_multi
   import tusca_uc_pkg::*;
#(
   parameter  int N_SENSORES     = 4,
   parameter  int DELAY_CICLOS   = 50000000,
   parameter  int TIMEOUT_CICLOS = 5000000,
   localparam int CW             = largura(N_SENSORES)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  parar,
   input  logic                  pronto_medida,
   input  logic                  definir_config,
   input  logic                  pronto_config,
   output logic [N_SENSORES-1:0] medir,
   output logic [CW-1:0]         sensor_sel,
   output logic                  receber_config,
   output logic                  fim_ciclo,
   output logic [N_SENSORES-1:0] erro_timeout,
   output logic [ESTADO_W-1:0]   db_estado
);

   localparam int            DW     = largura(DELAY_CICLOS);
   localparam int            TW     = largura(TIMEOUT_CICLOS);
   localparam logic [CW-1:0] ULTIMO = CW'(N_SENSORES - 1);

   estado_t               estado_q, estado_d;
   logic [CW-1:0]         sel_q, sel_d;
   logic [N_SENSORES-1:0] erro_q, erro_d;
   logic [N_SENSORES-1:0] sel_oh;
   logic                  ultimo;
   logic                  zera_delay, conta_delay, fim_delay;
   logic                  zera_timeout, conta_timeout, fim_timeout;
   logic [DW-1:0]         cnt_delay;
   logic [TW-1:0]         cnt_timeout;
   logic                  unused_cnt;

   assign sel_oh = N_SENSORES'(1) << sel_q;
   assign ultimo = (sel_q == ULTIMO);

   // Both counters are cleared in the state just before the one that
   // counts, so each counting state starts from zero.
   assign zera_delay    = (estado_q == RESETA_DELAY);
   assign conta_delay   = (estado_q == ESPERA_DELAY);
   assign zera_timeout  = (estado_q == MEDE);
   assign conta_timeout = (estado_q == ESPERA_MEDIDA);

   // Counter values are only needed through their terminal flags.
   assign unused_cnt = ^{cnt_delay, cnt_timeout};

   tusca_contador_m #(.M(DELAY_CICLOS)) u_delay (
      .clock (clock),
      .reset (reset),
      .zera  (zera_delay),
      .conta (conta_delay),
      .q     (cnt_delay),
      .fim   (fim_delay)
   );

   tusca_contador_m #(.M(TIMEOUT_CICLOS)) u_timeout (
      .clock (clock),
      .reset (reset),
      .zera  (zera_timeout),
      .conta (conta_timeout),
      .q     (cnt_timeout),
      .fim   (fim_timeout)
   );

   // State, sensor index and sticky timeout flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= INICIAL;
         sel_q    <= '0;
         erro_q   <= '0;
      end else begin
         estado_q <= estado_d;
         sel_q    <= sel_d;
         erro_q   <= erro_d;
      end
   end

   // Next state; an answer on the deadline cycle still counts as on time.
   always_comb begin
      estado_d = estado_q;
      sel_d    = sel_q;
      erro_d   = erro_q;
      case (estado_q)
         INICIAL: begin
            if (start) begin
               estado_d = MEDE;
               sel_d    = '0;
            end
         end
         MEDE: estado_d = ESPERA_MEDIDA;
         ESPERA_MEDIDA: begin
            if (pronto_medida) begin
               estado_d = PROXIMO;
               erro_d   = erro_q & ~sel_oh;
            end else if (fim_timeout) begin
               estado_d = PROXIMO;
               erro_d   = erro_q | sel_oh;
            end
         end
         PROXIMO: begin
            if (ultimo) begin
               sel_d    = '0;
               estado_d = RESETA_DELAY;
            end else begin
               sel_d    = sel_q + CW'(1);
               estado_d = MEDE;
            end
         end
         RESETA_DELAY: estado_d = ESPERA_DELAY;
         ESPERA_DELAY: begin
            if (fim_delay) begin
               estado_d = MEDE;
            end else if (parar) begin
               estado_d = INICIAL;
            end else if (definir_config) begin
               estado_d = PEDIR_CONFIG;
            end
         end
         PEDIR_CONFIG: estado_d = ESPERA_CONFIG;
         ESPERA_CONFIG: begin
            if (pronto_config) begin
               estado_d = RESETA_DELAY;
            end
         end
         default: estado_d = INICIAL;
      endcase
   end

   // Moore output pulses decoded from the registered state.
   always_comb begin
      medir          = '0;
      receber_config = 1'b0;
      fim_ciclo      = 1'b0;
      case (estado_q)
         MEDE:         medir          = sel_oh;
         PROXIMO:      fim_ciclo      = ultimo;
         PEDIR_CONFIG: receber_config = 1'b1;
         default:      ;
      endcase
   end

   assign sensor_sel   = sel_q;
   assign erro_timeout = erro_q;
   assign db_estado    = estado_q;

endmodule

// File: tb/tb_tusca_uc_multi.sv
// Directed bench for tusca_uc_multi with N_SENSORES=3, DELAY_CICLOS=10,
// TIMEOUT_CICLOS=6.
module tb_tusca_uc_multi;

   localparam int N = 3;
   localparam int D = 10;
   localparam int T = 6;

   logic         clock = 1'b0;
   logic         reset, start, parar, pronto_medida, definir_config, pronto_config;
   logic [N-1:0] medir;
   logic [1:0]   sensor_sel;
   logic         receber_config, fim_ciclo;
   logic [N-1:0] erro_timeout;
   logic [3:0]   db_estado;

   int n_checks = 0;
   int n_pass   = 0;

   tusca_uc_multi #(
      .N_SENSORES     (N),
      .DELAY_CICLOS   (D),
      .TIMEOUT_CICLOS (T)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .parar          (parar),
      .pronto_medida  (pronto_medida),
      .definir_config (definir_config),
      .pronto_config  (pronto_config),
      .medir          (medir),
      .sensor_sel     (sensor_sel),
      .receber_config (receber_config),
      .fim_ciclo      (fim_ciclo),
      .erro_timeout   (erro_timeout),
      .db_estado      (db_estado)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_checks++;
      if (obs === esp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Entered in MEDE for sensor sens; answers on ESPERA_MEDIDA cycle lat
   // (lat=0: never answers). Leaves in PROXIMO.
   task automatic medida(input int sens, input int lat, input string tag);
      int n;
      n = 0;
      verifica({tag, "_medir"}, medir, 32'(1 << sens));
      verifica({tag, "_sel"}, sensor_sel, sens);
      tick();
      while (db_estado == 4'd2 && n < 20) begin
         n++;
         pronto_medida = (lat != 0 && n == lat);
         tick();
      end
      pronto_medida = 1'b0;
      verifica({tag, "_ciclos"}, n, (lat == 0) ? T : lat);
   endtask

   // One full sweep starting in MEDE for sensor 0; ends in RESETA_DELAY.
   task automatic varredura(input int l0, input int l1, input int l2,
                            input logic [2:0] erro_esp, input string tag);
      int lat[3];
      lat = '{l0, l1, l2};
      for (int s = 0; s < 3; s++) begin
         medida(s, lat[s], $sformatf("%s_s%0d", tag, s));
         verifica($sformatf("%s_fim%0d", tag, s), fim_ciclo, (s == 2));
         tick();
      end
      verifica({tag, "_erro"}, erro_timeout, erro_esp);
   endtask

   // From RESETA_DELAY, counts cycles spent in ESPERA_DELAY.
   task automatic conta_delay(input string tag, input int esperado);
      int n;
      n = 0;
      verifica({tag, "_reseta"}, db_estado, 4);
      tick();
      while (db_estado == 4'd5 && n < 40) begin
         n++;
         tick();
      end
      verifica({tag, "_ciclos"}, n, esperado);
      verifica({tag, "_mede"}, db_estado, 1);
      verifica({tag, "_medir0"}, medir, 1);
   endtask

   task automatic verifica_reset(input string tag);
      verifica({tag, "_estado"}, db_estado, 0);
      verifica({tag, "_sel"}, sensor_sel, 0);
      verifica({tag, "_erro"}, erro_timeout, 0);
      verifica({tag, "_medir"}, medir, 0);
      verifica({tag, "_receber"}, receber_config, 0);
      verifica({tag, "_fim"}, fim_ciclo, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; parar = 1'b0; pronto_medida = 1'b0;
      definir_config = 1'b0; pronto_config = 1'b0;
      tick(); tick();
      verifica_reset("rst");
      reset = 1'b0;
      tick();
      verifica("inicial_parado", db_estado, 0);
      start = 1'b1; tick(); start = 1'b0;
      verifica("start_mede", db_estado, 1);

      // normal sweep, then an uninterrupted delay
      varredura(3, 3, 3, 3'b000, "v1");
      conta_delay("d1", D);

      // sensor 1 silent, then recovers on the next sweep
      varredura(3, 0, 3, 3'b010, "v2");
      conta_delay("d2", D);
      varredura(3, 3, 3, 3'b000, "v3");

      // configuration request on delay cycle 4 restarts the full delay
      verifica("cfg_reseta", db_estado, 4);
      tick(); tick(); tick(); tick();
      verifica("cfg_em_delay", db_estado, 5);
      definir_config = 1'b1; tick(); definir_config = 1'b0;
      verifica("cfg_pedir", db_estado, 6);
      verifica("cfg_receber", receber_config, 1);
      tick();
      verifica("cfg_receber_pulso", receber_config, 0);
      verifica("cfg_espera", db_estado, 7);
      tick(); tick(); tick(); tick();
      verifica("cfg_sem_timeout", db_estado, 7);
      pronto_config = 1'b1; tick(); pronto_config = 1'b0;
      conta_delay("d3", D);

      // answer on the deadline cycle: no error
      varredura(3, T, 3, 3'b000, "v4");

      // terminal delay count beats parar and definir_config
      tick();
      repeat (9) tick();
      verifica("prio_espera", db_estado, 5);
      parar = 1'b1; definir_config = 1'b1; tick();
      parar = 1'b0; definir_config = 1'b0;
      verifica("prio_mede", db_estado, 1);
      verifica("prio_medir", medir, 1);

      // parar mid-delay returns to INICIAL; start resumes from sensor 0
      varredura(3, 3, 3, 3'b000, "v5");
      tick();
      repeat (3) tick();
      parar = 1'b1; tick(); parar = 1'b0;
      verifica("parar_inicial", db_estado, 0);
      tick();
      verifica("parar_fica", db_estado, 0);
      start = 1'b1; tick(); start = 1'b0;
      verifica("restart_mede", db_estado, 1);
      verifica("restart_sel", sensor_sel, 0);
      verifica("restart_medir", medir, 1);

      // reset in ESPERA_MEDIDA with a pending error flag
      medida(0, 0, "r1_s0");
      tick();
      verifica("r1_erro", erro_timeout, 3'b001);
      verifica("r1_sel", sensor_sel, 1);
      tick();
      verifica("r1_espera", db_estado, 2);
      start = 1'b1; tick();
      verifica("r1_start_ignorado", db_estado, 2);
      start = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      verifica_reset("r1");
      tick();
      verifica("r1_fica", db_estado, 0);

      // reset in ESPERA_CONFIG
      start = 1'b1; tick(); start = 1'b0;
      varredura(1, 1, 0, 3'b100, "v6");
      tick();
      definir_config = 1'b1; tick(); definir_config = 1'b0;
      verifica("r2_pedir", db_estado, 6);
      tick();
      start = 1'b1; tick();
      verifica("r2_start_ignorado", db_estado, 7);
      start = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      verifica_reset("r2");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
